// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared state enum and grant encodings for the register-bank sequencer
package regbank_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } seq_state_t;

    // One-hot grant vector: bit 0 = writeback, bit 1 = load unit
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_WB   = 2'b01;
    localparam logic [1:0] GNT_LD   = 2'b10;

endpackage

// File: rtl/regbank_sequencer_arbiter.sv
// rtl/regbank_sequencer_arbiter.sv - two-way round-robin arbiter (module rr_arbiter2)
module rr_arbiter2
    import regbank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Set when writeback wins the next tie, i.e. load was granted most recently
    logic wb_first;

    always_comb begin
        gnt = GNT_NONE;
        if (en) begin
            case (req)
                2'b01:   gnt = GNT_WB;
                2'b10:   gnt = GNT_LD;
                2'b11:   gnt = wb_first ? GNT_WB : GNT_LD;
                default: gnt = GNT_NONE;
            endcase
        end
    end

    // Every grant is an accepted handshake, so the pointer follows the grant directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_first <= 1'b1;
        end else if (gnt == GNT_WB) begin
            wb_first <= 1'b0;
        end else if (gnt == GNT_LD) begin
            wb_first <= 1'b1;
        end
    end

endmodule

// File: rtl/regbank_sequencer.sv
// rtl/regbank_sequencer.sv - register-bank write sequencer; clear-on-reset guarded by REGBANK_SEQ_CLEAR_EN
module regbank_sequencer
    import regbank_pkg::*;
#(
    parameter int BANK_WIDTH     = 5,
    parameter int REGISTER_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      wb_valid,
    input  logic [BANK_WIDTH-1:0]     wb_sel,
    input  logic [REGISTER_WIDTH-1:0] wb_data,
    output logic                      wb_ready,
    input  logic                      ld_valid,
    input  logic [BANK_WIDTH-1:0]     ld_sel,
    input  logic [REGISTER_WIDTH-1:0] ld_data,
    output logic                      ld_ready,
    output logic                      reg_w,
    output logic [BANK_WIDTH-1:0]     rd_sel,
    output logic [REGISTER_WIDTH-1:0] rd_data,
    output logic                      ready
);

    logic [1:0]                gnt;
    logic                      grant_any;
    logic [BANK_WIDTH-1:0]     gnt_sel;
    logic [REGISTER_WIDTH-1:0] gnt_data;
    logic                      clearing;
    logic [BANK_WIDTH-1:0]     clear_idx;

`ifdef REGBANK_SEQ_CLEAR_EN
    seq_state_t            state, state_next;
    logic [BANK_WIDTH-1:0] idx, idx_next;
    logic                  run_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // A clr cycle issues no write; the following SIZE cycles sweep idx 0..SIZE-1
    always_comb begin
        state_next = state;
        idx_next   = idx;
        run_ready  = 1'b0;
        clearing   = 1'b0;
        case (state)
            CLEAR: begin
                if (clr) begin
                    idx_next = '0;
                end else begin
                    clearing = 1'b1;
                    idx_next = idx + BANK_WIDTH'(1);
                    if (&idx) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (clr) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end else begin
                    run_ready = 1'b1;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign ready     = run_ready & ~rst;
    assign clear_idx = idx;
`else
    logic unused_clr;

    assign unused_clr = clr;
    assign ready      = ~rst;
    assign clearing   = 1'b0;
    assign clear_idx  = '0;
`endif

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (ready),
        .req ({ld_valid, wb_valid}),
        .gnt (gnt)
    );

    assign wb_ready  = (gnt == GNT_WB);
    assign ld_ready  = (gnt == GNT_LD);
    assign grant_any = (gnt != GNT_NONE);
    assign gnt_sel   = (gnt == GNT_LD) ? ld_sel  : wb_sel;
    assign gnt_data  = (gnt == GNT_LD) ? ld_data : wb_data;

    // Register 0 is hardwired: its handshake completes but nothing is written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_w   <= 1'b0;
            rd_sel  <= '0;
            rd_data <= '0;
        end else if (clearing) begin
            reg_w   <= 1'b1;
            rd_sel  <= clear_idx;
            rd_data <= '0;
        end else if (grant_any && (gnt_sel != '0)) begin
            reg_w   <= 1'b1;
            rd_sel  <= gnt_sel;
            rd_data <= gnt_data;
        end else begin
            reg_w   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regbank_sequencer.sv
// tb/tb_regbank_sequencer.sv - self-checking bench for regbank_sequencer (REGBANK_SEQ_CLEAR_EN on or off)
module tb_regbank_sequencer;

    localparam int BW   = 5;
    localparam int RW   = 32;
    localparam int SIZE = 2 ** BW;
`ifdef REGBANK_SEQ_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          wb_valid = 1'b0;
    logic [BW-1:0] wb_sel = '0;
    logic [RW-1:0] wb_data = '0;
    logic          wb_ready;
    logic          ld_valid = 1'b0;
    logic [BW-1:0] ld_sel = '0;
    logic [RW-1:0] ld_data = '0;
    logic          ld_ready;
    logic          reg_w;
    logic [BW-1:0] rd_sel;
    logic [RW-1:0] rd_data;
    logic          ready;

    int total = 0;
    int bad   = 0;

    regbank_sequencer #(.BANK_WIDTH(BW), .REGISTER_WIDTH(RW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data), .wb_ready(wb_ready),
        .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_data(ld_data), .ld_ready(ld_ready),
        .reg_w(reg_w), .rd_sel(rd_sel), .rd_data(rd_data), .ready(ready)
    );

    always #5 clk = ~clk;

    // Reference model: pending clear writes, who was granted last, expected bank-port contents
    int            m_clear_left;
    int            m_clear_next;
    bit            m_last_wb;
    logic          m_w;
    logic [BW-1:0] m_sel;
    logic [RW-1:0] m_data;

    task automatic model_reset();
        m_clear_left = CLR_EN ? SIZE : 0;
        m_clear_next = 0;
        m_last_wb    = 1'b0;
        m_w          = 1'b0;
        m_sel        = '0;
        m_data       = '0;
    endtask

    task automatic model_step(output logic e_wr, output logic e_lr, output logic e_rdy);
        logic [BW-1:0] s;
        logic [RW-1:0] d;
        int            cn;
        e_wr = 1'b0; e_lr = 1'b0; e_rdy = 1'b0;
        if (CLR_EN && clr) begin
            m_clear_left = SIZE;
            m_clear_next = 0;
            m_w          = 1'b0;
        end else if (m_clear_left > 0) begin
            cn           = m_clear_next;
            m_w          = 1'b1;
            m_sel        = cn[BW-1:0];
            m_data       = '0;
            m_clear_next = m_clear_next + 1;
            m_clear_left = m_clear_left - 1;
        end else begin
            e_rdy = 1'b1;
            if (wb_valid && ld_valid) begin
                e_wr = !m_last_wb;
                e_lr = m_last_wb;
            end else begin
                e_wr = wb_valid;
                e_lr = ld_valid;
            end
            if (e_wr || e_lr) m_last_wb = e_wr;
            s = e_wr ? wb_sel  : ld_sel;
            d = e_wr ? wb_data : ld_data;
            if ((e_wr || e_lr) && s != 0) begin
                m_w = 1'b1; m_sel = s; m_data = d;
            end else begin
                m_w = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs already driven; checks handshake outputs mid-cycle and bank port after the edge
    task automatic step(input string nm, input bit use_model,
                        input logic x_wr, input logic x_lr, input logic x_rdy,
                        input logic x_w, input logic [BW-1:0] x_sel, input logic [RW-1:0] x_data);
        logic e_wr, e_lr, e_rdy, e_w;
        logic [BW-1:0] e_sel;
        logic [RW-1:0] e_data;
        model_step(e_wr, e_lr, e_rdy);
        e_w = m_w; e_sel = m_sel; e_data = m_data;
        if (!use_model) begin
            e_wr = x_wr; e_lr = x_lr; e_rdy = x_rdy;
            e_w = x_w; e_sel = x_sel; e_data = x_data;
        end
        #1;
        chk({nm, " wb_ready"}, RW'(wb_ready), RW'(e_wr));
        chk({nm, " ld_ready"}, RW'(ld_ready), RW'(e_lr));
        chk({nm, " ready"},    RW'(ready),    RW'(e_rdy));
        @(posedge clk);
        #1;
        chk({nm, " reg_w"},   RW'(reg_w),  RW'(e_w));
        chk({nm, " rd_sel"},  RW'(rd_sel), RW'(e_sel));
        chk({nm, " rd_data"}, rd_data,     e_data);
    endtask

    task automatic do_reset(input string nm);
        wb_valid = 1'b1; ld_valid = 1'b1; wb_sel = 5'd3; ld_sel = 5'd4;
        rst = 1'b1;
        #1;
        chk({nm, " reg_w"},    RW'(reg_w),    '0);
        chk({nm, " rd_sel"},   RW'(rd_sel),   '0);
        chk({nm, " rd_data"},  rd_data,       '0);
        chk({nm, " ready"},    RW'(ready),    '0);
        chk({nm, " wb_ready"}, RW'(wb_ready), '0);
        chk({nm, " ld_ready"}, RW'(ld_ready), '0);
        @(posedge clk);
        #1;
        chk({nm, " held reg_w"}, RW'(reg_w), '0);
        rst = 1'b0; clr = 1'b0; wb_valid = 1'b0; ld_valid = 1'b0;
        model_reset();
    endtask

    task automatic clear_sweep(input string nm, input int count);
        for (int i = 0; i < count; i++) begin
            wb_valid = 1'b1; wb_sel = 5'd6; ld_valid = 1'b0;
            step(nm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BW'(i), '0);
        end
    endtask

    typedef struct {
        logic          wv;
        logic [BW-1:0] ws;
        logic [RW-1:0] wd;
        logic          lv;
        logic [BW-1:0] ls;
        logic [RW-1:0] ldd;
        logic          e_wr;
        logic          e_lr;
        logic          e_w;
        logic [BW-1:0] e_sel;
        logic [RW-1:0] e_data;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 5'd1,  32'h1111_0001, 1'b1, 5'd2, 32'h2222_0002, 1'b1, 1'b0, 1'b1, 5'd1,  32'h1111_0001};
        tbl[1] = '{1'b1, 5'd1,  32'h1111_0001, 1'b1, 5'd2, 32'h2222_0002, 1'b0, 1'b1, 1'b1, 5'd2,  32'h2222_0002};
        tbl[2] = '{1'b1, 5'd1,  32'h1111_0001, 1'b1, 5'd2, 32'h2222_0002, 1'b1, 1'b0, 1'b1, 5'd1,  32'h1111_0001};
        tbl[3] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd2, 32'h2222_0002, 1'b1, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF};
        tbl[4] = '{1'b0, 5'd5,  32'hDEAD_BEEF, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF};
        tbl[5] = '{1'b0, 5'd9,  32'h0BAD_0BAD, 1'b0, 5'd8, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF};
        tbl[6] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 5'd7, 32'h0000_0077, 1'b1, 1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5};
        tbl[7] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 1'b1, 1'b1, 5'd7,  32'h0000_0077};
        tbl[8] = '{1'b1, 5'd0,  32'h0000_FFFF, 1'b0, 5'd7, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 5'd7,  32'h0000_0077};
        tbl[9] = '{1'b1, 5'd3,  32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 5'd4,  32'h0000_0044};

        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset");

        if (CLR_EN) clear_sweep("initial clear", SIZE);

        for (int i = 0; i < 10; i++) begin
            wb_valid = tbl[i].wv; wb_sel = tbl[i].ws; wb_data = tbl[i].wd;
            ld_valid = tbl[i].lv; ld_sel = tbl[i].ls; ld_data = tbl[i].ldd;
            step($sformatf("vec%0d", i), 1'b0, tbl[i].e_wr, tbl[i].e_lr, 1'b1,
                 tbl[i].e_w, tbl[i].e_sel, tbl[i].e_data);
        end

        wb_valid = 1'b1; wb_sel = 5'd9;  wb_data = 32'h0000_0099;
        ld_valid = 1'b1; ld_sel = 5'd10; ld_data = 32'h0000_00AA;
        clr = 1'b1;
`ifdef REGBANK_SEQ_CLEAR_EN
        step("clr pulse", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 32'h0000_0044);
        clr = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            step($sformatf("reclear%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BW'(i), '0);
        end
        wb_valid = 1'b1; ld_valid = 1'b1;
        step("pending wb", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0099);
        step("pending ld", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_00AA);
        do_reset("reset after run");
        clear_sweep("partial clear", 11);
        do_reset("reset mid clear");
        clear_sweep("restart clear", SIZE);
`else
        step("clr ignored", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0099);
        clr = 1'b0;
        step("after clr", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_00AA);
        do_reset("reset mid run");
        wb_valid = 1'b1; wb_sel = 5'd3; wb_data = 32'h0000_0333;
        ld_valid = 1'b1; ld_sel = 5'd4; ld_data = 32'h0000_0444;
        step("post reset wb first", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0333);
`endif

        for (int i = 0; i < 400; i++) begin
            wb_valid = ($urandom % 3) != 0;
            ld_valid = ($urandom % 3) != 0;
            wb_sel   = (($urandom % 6) == 0) ? '0 : BW'($urandom);
            ld_sel   = (($urandom % 6) == 0) ? '0 : BW'($urandom);
            wb_data  = $urandom;
            ld_data  = $urandom;
            clr      = ($urandom % 40) == 0;
            step($sformatf("rand%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        end
        clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
